password_unlocker: RTL and testbench

//  Entry-side controller for the password lock. Latches the user's switch entry on a

---
 rtl/password_unlocker.sv | 150 +++++++++++++++
 tb/tb_password_unlocker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/password_unlocker.sv
// password_unlocker
//    Entry-side controller for the password lock. Latches the switch entry on a
//    check press and presents it to password_checker with a one-cycle is_check
//    strobe, consuming the checker's match result in that same cycle. Counts
//    consecutive failures, enforces a timed lockout after MAX_TRIES failures and
//    holds the unlocked state until a relock press.
//
//    Optional build macro: AUTO_RELOCK_EN -- when defined, UNLOCKED also ends
//    automatically after RELOCK_CYCLES cycles.
//
// Ports
//    clk            in   system clock, rising edge
//    reset          in   asynchronous, active-high
//    check_btn      in   synchronised level; rising edge submits an attempt
//    relock_btn     in   synchronised level; rising edge relocks
//    sw[15:0]       in   entered password
//    has_pass       in   a password is stored in the checker
//    match          in   checker result, valid while is_check=1
//    inserted_pass  out  latched entry presented to the checker
//    is_check       out  one-cycle compare strobe
//    unlocked       out  access granted
//    locked_out     out  lockout active
//    fail_count     out  consecutive failures so far
//    lockout_remain out  lockout cycles left, 0 outside lockout
module password_unlocker #(
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 50_000_000,
   parameter int unsigned RELOCK_CYCLES  = 250_000_000
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                check_btn,
   input  logic                                relock_btn,
   input  logic [15:0]                         sw,
   input  logic                                has_pass,
   input  logic                                match,
   output logic [15:0]                         inserted_pass,
   output logic                                is_check,
   output logic                                unlocked,
   output logic                                locked_out,
   output logic [$clog2(MAX_TRIES+1)-1:0]      fail_count,
   output logic [$clog2(LOCKOUT_CYCLES)-1:0]   lockout_remain
);

   localparam int unsigned FW = $clog2(MAX_TRIES + 1);
   localparam int unsigned LW = $clog2(LOCKOUT_CYCLES);
   localparam logic [FW-1:0] LAST_FAIL = FW'(MAX_TRIES - 1);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

   if (MAX_TRIES < 1 || LOCKOUT_CYCLES < 2 || RELOCK_CYCLES < 2) begin : g_param_check
      $error("password_unlocker: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      UNLOCKED,
      LOCKOUT
   } state_t;

   state_t state, state_next;

   logic check_prev, relock_prev;
   logic check_edge, relock_edge;

   assign check_edge  = check_btn  & ~check_prev;
   assign relock_edge = relock_btn & ~relock_prev;

`ifdef AUTO_RELOCK_EN
   localparam int unsigned RW = $clog2(RELOCK_CYCLES);
   localparam logic [RW-1:0] RELOCK_LOAD = RW'(RELOCK_CYCLES - 1);
   logic [RW-1:0] relock_timer;
`endif

   always_comb begin
      state_next = state;
      is_check   = 1'b0;
      unlocked   = 1'b0;
      locked_out = 1'b0;
      case (state)
         IDLE: begin
            if (check_edge) state_next = has_pass ? CHECK : UNLOCKED;
         end
         CHECK: begin
            is_check = 1'b1;
            if (match)                        state_next = UNLOCKED;
            else if (fail_count >= LAST_FAIL) state_next = LOCKOUT;
            else                              state_next = IDLE;
         end
         UNLOCKED: begin
            unlocked = 1'b1;
            if (relock_edge) state_next = IDLE;
`ifdef AUTO_RELOCK_EN
            else if (relock_timer == '0) state_next = IDLE;
`endif
         end
         LOCKOUT: begin
            locked_out = 1'b1;
            if (lockout_remain == '0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Button history resets high so a button held through reset is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         check_prev     <= 1'b1;
         relock_prev    <= 1'b1;
         inserted_pass  <= '0;
         fail_count     <= '0;
         lockout_remain <= '0;
      end else begin
         check_prev  <= check_btn;
         relock_prev <= relock_btn;
         if (state == IDLE && check_edge && has_pass) inserted_pass <= sw;
         if (state == CHECK) begin
            if (match) begin
               fail_count <= '0;
            end else if (fail_count >= LAST_FAIL) begin
               fail_count     <= '0;
               lockout_remain <= LOCK_LOAD;
            end else begin
               fail_count <= fail_count + FW'(1);
            end
         end
         if (state == LOCKOUT && lockout_remain != '0)
            lockout_remain <= lockout_remain - LW'(1);
      end
   end

`ifdef AUTO_RELOCK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         relock_timer <= '0;
      end else if (state != UNLOCKED && state_next == UNLOCKED) begin
         relock_timer <= RELOCK_LOAD;
      end else if (state == UNLOCKED) begin
         if (state_next != UNLOCKED) relock_timer <= '0;
         else                        relock_timer <= relock_timer - RW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_password_unlocker.sv
// tb_password_unlocker
//    Directed scenarios with literal expectations followed by randomized
//    stimulus, all checked every cycle against a timeline model that tracks
//    lockout and auto-relock as absolute cycle deadlines.
module tb_password_unlocker;

   localparam int MAX  = 3;
   localparam int LOCK = 8;
   localparam int REL  = 16;
`ifdef AUTO_RELOCK_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        check_btn, relock_btn, has_pass, match;
   logic [15:0] sw, stored;
   logic [15:0] inserted_pass;
   logic        is_check, unlocked, locked_out;
   logic [1:0]  fail_count;
   logic [2:0]  lockout_remain;

   password_unlocker #(
      .MAX_TRIES      (MAX),
      .LOCKOUT_CYCLES (LOCK),
      .RELOCK_CYCLES  (REL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .check_btn      (check_btn),
      .relock_btn     (relock_btn),
      .sw             (sw),
      .has_pass       (has_pass),
      .match          (match),
      .inserted_pass  (inserted_pass),
      .is_check       (is_check),
      .unlocked       (unlocked),
      .locked_out     (locked_out),
      .fail_count     (fail_count),
      .lockout_remain (lockout_remain)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      tests++;
      if (act !== 32'(exp)) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycle index plus absolute deadlines for lockout/relock.
   int          cyc, lock_end, unl_end, m_fails;
   bit          m_check, m_unl, pc, pr;
   logic [15:0] m_pass;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc <= 0; lock_end <= 0; unl_end <= 0; m_fails <= 0;
         m_check <= 0; m_unl <= 0; m_pass <= '0; pc <= 1; pr <= 1;
      end else begin
         pc  <= check_btn;
         pr  <= relock_btn;
         cyc <= cyc + 1;
         if (m_check) begin
            m_check <= 0;
            if (match) begin
               m_unl <= 1; m_fails <= 0; unl_end <= cyc + 1 + REL;
            end else if (m_fails + 1 == MAX) begin
               lock_end <= cyc + 1 + LOCK; m_fails <= 0;
            end else begin
               m_fails <= m_fails + 1;
            end
         end else if (cyc < lock_end) begin
            // locked out: every press ignored
         end else if (m_unl) begin
            if (relock_btn && !pr)           m_unl <= 0;
            else if (AUTO && cyc + 1 == unl_end) m_unl <= 0;
         end else if (check_btn && !pc) begin
            if (has_pass) begin
               m_check <= 1; m_pass <= sw;
            end else begin
               m_unl <= 1; unl_end <= cyc + 1 + REL;
            end
         end
      end
   end

   // Behavioural password_checker.
   always @(negedge clk) match <= (m_pass == stored);

   always @(negedge clk) begin
      if (!reset) begin
         chk("is_check",       is_check,       m_check);
         chk("unlocked",       unlocked,       m_unl);
         chk("locked_out",     locked_out,     cyc < lock_end);
         chk("lockout_remain", lockout_remain, (cyc < lock_end) ? lock_end - 1 - cyc : 0);
         chk("fail_count",     fail_count,     m_fails);
         chk("inserted_pass",  inserted_pass,  m_pass);
      end
   end

   task automatic after_edge();
      @(posedge clk); #1;
   endtask

   // Press check for one cycle; returns is_check seen the cycle after the edge.
   task automatic attempt(input logic [15:0] v, output logic ic);
      @(negedge clk); sw = v; check_btn = 1'b1;
      after_edge(); ic = is_check;
      @(negedge clk); check_btn = 1'b0;
      after_edge();
   endtask

   task automatic relock();
      @(negedge clk); relock_btn = 1'b1;
      @(negedge clk); relock_btn = 1'b0;
      after_edge();
      chk("relock_unlocked", unlocked, 0);
   endtask

   logic ic;
   int   cnt;
   int   seen;

   initial begin
      reset = 1'b1; check_btn = 0; relock_btn = 0; has_pass = 1; sw = '0;
      stored = 16'hA5A5; match = 0;
      #1;
      chk("rst_unlocked", unlocked, 0);
      chk("rst_locked",   locked_out, 0);
      chk("rst_is_check", is_check, 0);
      chk("rst_pass",     inserted_pass, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // 1: correct entry
      @(negedge clk); sw = 16'hA5A5; check_btn = 1'b1;
      after_edge();
      chk("t1_is_check", is_check, 1);
      chk("t1_pass",     inserted_pass, 16'hA5A5);
      chk("t1_unl_early", unlocked, 0);
      @(negedge clk); check_btn = 1'b0;
      after_edge();
      chk("t1_is_check_off", is_check, 0);
      chk("t1_unlocked", unlocked, 1);
      chk("t1_fail",     fail_count, 0);

      // 4: relock and check rising together
      @(negedge clk); relock_btn = 1'b1; check_btn = 1'b1;
      after_edge();
      chk("t4_unlocked", unlocked, 0);
      chk("t4_is_check", is_check, 0);
      @(negedge clk); relock_btn = 1'b0; check_btn = 1'b0;
      after_edge();
      chk("t4_is_check2", is_check, 0);

      // 2: three failures into lockout
      attempt(16'h0001, ic); chk("t2_fail1", fail_count, 1);
      attempt(16'h0001, ic); chk("t2_fail2", fail_count, 2);
      attempt(16'h0001, ic);
      chk("t2_locked", locked_out, 1);
      chk("t2_fail0",  fail_count, 0);
      chk("t2_remain", lockout_remain, 7);
      cnt = 1; seen = 0;
      for (int i = 1; i < 20; i++) begin
         @(negedge clk);
         if (i == 2) check_btn = 1'b1;
         if (i == 4) check_btn = 1'b0;
         after_edge();
         if (locked_out) cnt++;
         if (is_check) seen++;
      end
      chk("t2_lock_len", cnt, 8);
      chk("t2_no_check", seen, 0);

      // 3: two failures then correct
      attempt(16'h0001, ic);
      attempt(16'h0001, ic); chk("t3_fail2", fail_count, 2);
      attempt(16'hA5A5, ic);
      chk("t3_unlocked", unlocked, 1);
      chk("t3_fail0",    fail_count, 0);
      relock();

      // 5: no stored password
      has_pass = 1'b0;
      attempt(16'h1234, ic);
      chk("t5_is_check", ic, 0);
      chk("t5_unlocked", unlocked, 1);
      relock();
      has_pass = 1'b1;

      // 6: reset during lockout with check held across release
      attempt(16'h0001, ic); attempt(16'h0001, ic); attempt(16'h0001, ic);
      repeat (3) after_edge();
      chk("t6_remain4", lockout_remain, 4);
      #1; reset = 1'b1; check_btn = 1'b1;
      #1;
      chk("t6_locked", locked_out, 0);
      chk("t6_remain", lockout_remain, 0);
      chk("t6_fail",   fail_count, 0);
      chk("t6_pass",   inserted_pass, 0);
      @(negedge clk); @(negedge clk); reset = 1'b0;
      seen = 0;
      repeat (4) begin
         after_edge();
         if (is_check || unlocked) seen++;
      end
      chk("t6_no_attempt", seen, 0);
      @(negedge clk); check_btn = 1'b0;
      attempt(16'hA5A5, ic);
      chk("t6_is_check", ic, 1);
      chk("t6_unlocked", unlocked, 1);
      relock();

      // 7: auto-relock (or indefinite hold without it)
      attempt(16'hA5A5, ic);
`ifdef AUTO_RELOCK_EN
      cnt = 1;
      repeat (30) begin
         after_edge();
         if (unlocked) cnt++;
      end
      chk("t7_unlock_len", cnt, 16);
`else
      repeat (40) after_edge();
      chk("t7_held", unlocked, 1);
      relock();
`endif

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         check_btn  = ($urandom_range(0, 3) == 0);
         relock_btn = ($urandom_range(0, 15) == 0);
         has_pass   = ($urandom_range(0, 7) != 0);
         sw         = ($urandom_range(0, 1) == 1) ? stored : 16'($urandom);
      end
      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
